alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one combinational RV32 ALU between two requesters, e.g. the integer pipe (req 0) and the address/branch unit (req 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one operation issued per cycle; registered operands and registered per-requester results.
- Drives the external ALU instance through the alu_* ports.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 4, opaque requester tag width; the tag is returned with the result.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- reqN_valid  in  1  request valid (N = 0,1)
- reqN_ready  out  1  request accepted when valid&ready
- reqN_op  in  4  ALU opcode (package encoding)
- reqN_a  in  XLEN  operand 1
- reqN_b  in  XLEN  operand 2
- reqN_tag  in  TAG_W  tag
- rspN_valid  out  1  result valid
- rspN_ready  in  1  result consumed when valid&ready
- rspN_data  out  XLEN  result
- rspN_tag  out  TAG_W  tag of the result
- alu_op  out  4  to ALU
- alu_i1  out  XLEN  to ALU
- alu_i2  out  XLEN  to ALU
- alu_o  in  XLEN  from ALU, combinational from alu_*

Behaviour:
- Clock and reset: single clock domain; rst_n is asynchronous, active-low.
- Reset: all outputs are 0, the RR pointer is 0, and all outstanding flags are clear.
- Reset mid-operation discards any in-flight op and any held result. No response is produced for it.
- Eligibility: elig_N = reqN_valid & (!out_N | (rspN_valid & rspN_ready)).
  - out_N is set on request accept and cleared on response handshake.
  - At most one op is outstanding per requester.
- Grant:
  - Exactly one eligible requester: it is granted.
  - Both eligible: the pointer's requester is granted, and the pointer then moves to the other requester.
  - The pointer does not change when nothing is granted.
- reqN_ready = grant_N. It may depend combinationally on reqN_valid and rspN_ready; requesters must not make valid depend on ready.
- Issue stage: on accept at edge E0, register {op, a, b, tag, id} into the issue register with iss_v = 1.
  - alu_* are driven from the issue register.
  - alu_* = 0 when iss_v = 0.
- Result capture: at E1, alu_o and the tag go into the rsp register of requester id, and rspN_valid is set.
- Latency: accept at E0 gives rsp valid after E1 (2 cycles).
- Throughput:
  - Alternating requesters: 1 op/cycle.
  - Single requester: 1 op per 2 cycles when rsp_ready is held high.
- Response hold: rspN_valid, rspN_data and rspN_tag hold stable until the handshake. The valid drops next cycle unless a new result is captured at the same edge.
- Simultaneous response pop and new capture for the same requester: capture wins and valid stays 1. This can only occur via the bypass term in elig.
- Opcodes are passed unchanged. An undefined opcode yields whatever the ALU returns (0), with a normal response.
- Width: no extension or truncation; the tag is carried verbatim.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, adds the following outputs:
  - grant0_cnt  out  32
  - grant1_cnt  out  32
  - conflict_cnt  out  32
- Counter behaviour:
  - grantN_cnt increments on each accept of requester N.
  - conflict_cnt increments in each cycle where both reqN_valid are high but only one is granted, or both are blocked by outstanding.
  - All three counters wrap at 2^32 and reset to 0.
- When not defined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - the opcode localparams ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111;
  - the issue-register struct type {op, a, b, tag, id}.
- Sub-module rr_arb2: 2-input round-robin picker holding the pointer flop. Inputs: elig[1:0], adv. Output: one-hot grant[1:0].

Test Plan:
- Single op: req0 ADD a=5, b=7, tag=3 → rsp0_valid 2 cycles after accept, data=12, tag=3; no rsp1.
- Contention: both valid every cycle; req0 SUB 10-3, req1 SLL 1<<4; rsp always ready → grants alternate 0,1,0,1 starting at 0; results 7 and 16; 1 accept/cycle.
- Backpressure: rsp0_ready=0 with a held result → req0_ready stays 0 and rsp0 data stays stable; req1 still issues. Raising rsp0_ready → same-cycle re-accept via bypass.
- Signed ops: SRA 0x80000000>>>4 = 0xF8000000; SLT -1<0 = 1; SLTU 0xFFFFFFFF<0 = 0, each returned on the requesting port.
- Reset mid-op: assert rst_n=0 the cycle after an accept → all rsp_valid and req_ready go 0 immediately, and no response appears after release.
- Stats (ALU_ARB_STATS_EN): 10 contended cycles → grant0_cnt=5, grant1_cnt=5, conflict_cnt=10.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and RV32 ALU opcode encoding for alu_share_arb.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_XLEN  = 32;
    localparam int ALU_TAG_W = 4;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b1000;
    localparam logic [3:0] SLL  = 4'b0001;
    localparam logic [3:0] SLT  = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011;
    localparam logic [3:0] XOR  = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] SRA  = 4'b1101;
    localparam logic [3:0] OR   = 4'b0110;
    localparam logic [3:0] AND  = 4'b0111;

    // Issue register contents; id selects the response slot on capture.
    typedef struct packed {
        logic [3:0]           op;
        logic [ALU_XLEN-1:0]  a;
        logic [ALU_XLEN-1:0]  b;
        logic [ALU_TAG_W-1:0] tag;
        logic                 id;
    } iss_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin picker with a one-bit priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    input  logic       adv,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After a contended grant the loser gets priority next time.
    assign ptr_d = adv ? grant[0] : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Round-robin sharing of one external combinational RV32 ALU
//               between two valid/ready requesters. Optional grant/conflict
//               counters when ALU_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb
    import alu_pkg::*;
#(
    // Must match the package widths, which size the issue register.
    parameter int XLEN  = ALU_XLEN,
    parameter int TAG_W = ALU_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [XLEN-1:0]  rsp0_data,
    output logic [TAG_W-1:0] rsp0_tag,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [XLEN-1:0]  rsp1_data,
    output logic [TAG_W-1:0] rsp1_tag,

    output logic [3:0]       alu_op,
    output logic [XLEN-1:0]  alu_i1,
    output logic [XLEN-1:0]  alu_i2,
`ifdef ALU_ARB_STATS_EN
    output logic [31:0]      grant0_cnt,
    output logic [31:0]      grant1_cnt,
    output logic [31:0]      conflict_cnt,
`endif
    input  logic [XLEN-1:0]  alu_o
);

    logic [1:0]       valid_v;
    logic [1:0]       rsp_ready_v;
    logic [1:0]       rsp_valid_v;
    logic [1:0]       rsp_hs;
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       cap;
    logic [XLEN-1:0]  rsp_data_v [2];
    logic [TAG_W-1:0] rsp_tag_v  [2];

    iss_t iss_q;
    iss_t iss_d;
    logic iss_v_q;
    logic iss_v_d;

    assign valid_v     = {req1_valid, req0_valid};
    assign rsp_ready_v = {rsp1_ready, rsp0_ready};

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig),
        .adv   (&elig),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Issue stage: latch the granted request; hold contents when idle.
    always_comb begin
        iss_d   = iss_q;
        iss_v_d = |grant;
        if (grant[1]) begin
            iss_d = '{op: req1_op, a: req1_a, b: req1_b, tag: req1_tag, id: 1'b1};
        end else if (grant[0]) begin
            iss_d = '{op: req0_op, a: req0_a, b: req0_b, tag: req0_tag, id: 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q   <= '0;
            iss_v_q <= 1'b0;
        end else begin
            iss_q   <= iss_d;
            iss_v_q <= iss_v_d;
        end
    end

    assign alu_op = iss_v_q ? iss_q.op : 4'd0;
    assign alu_i1 = iss_v_q ? iss_q.a  : '0;
    assign alu_i2 = iss_v_q ? iss_q.b  : '0;

    for (genvar n = 0; n < 2; n++) begin : g_rsp
        logic             out_q;
        logic             out_d;
        logic             vld_q;
        logic             vld_d;
        logic [XLEN-1:0]  data_q;
        logic [TAG_W-1:0] tag_q;

        assign rsp_hs[n] = vld_q & rsp_ready_v[n];
        // A held result being popped this cycle frees the slot for a new accept.
        // rst_n gating keeps ready low while reset is asserted.
        assign elig[n]   = rst_n & valid_v[n] & (~out_q | rsp_hs[n]);
        assign cap[n]    = iss_v_q & (iss_q.id == 1'(n));

        assign out_d = grant[n] | (out_q & ~rsp_hs[n]);
        assign vld_d = cap[n]   | (vld_q & ~rsp_hs[n]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q  <= 1'b0;
                vld_q  <= 1'b0;
                data_q <= '0;
                tag_q  <= '0;
            end else begin
                out_q <= out_d;
                vld_q <= vld_d;
                if (cap[n]) begin
                    data_q <= alu_o;
                    tag_q  <= iss_q.tag;
                end
            end
        end

        assign rsp_valid_v[n] = vld_q;
        assign rsp_data_v[n]  = data_q;
        assign rsp_tag_v[n]   = tag_q;
    end

    assign rsp0_valid = rsp_valid_v[0];
    assign rsp0_data  = rsp_data_v[0];
    assign rsp0_tag   = rsp_tag_v[0];
    assign rsp1_valid = rsp_valid_v[1];
    assign rsp1_data  = rsp_data_v[1];
    assign rsp1_tag   = rsp_tag_v[1];

`ifdef ALU_ARB_STATS_EN
    logic conflict_ev;

    // Grants are one-hot, so any cycle with both requests valid is a conflict.
    assign conflict_ev = req0_valid & req1_valid & ~(grant[0] & grant[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_cnt   <= 32'd0;
            grant1_cnt   <= 32'd0;
            conflict_cnt <= 32'd0;
        end else begin
            if (grant[0]) grant0_cnt <= grant0_cnt + 32'd1;
            if (grant[1]) grant1_cnt <= grant1_cnt + 32'd1;
            if (conflict_ev) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Directed self-checking bench for alu_share_arb with an ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [3:0]  rsp0_tag, rsp1_tag;
    logic [3:0]  alu_op;
    logic [31:0] alu_i1, alu_i2, alu_o;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] grant0_cnt, grant1_cnt, conflict_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_tag   (rsp0_tag),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_tag   (rsp1_tag),
        .alu_op     (alu_op),
        .alu_i1     (alu_i1),
        .alu_i2     (alu_i2),
`ifdef ALU_ARB_STATS_EN
        .grant0_cnt   (grant0_cnt),
        .grant1_cnt   (grant1_cnt),
        .conflict_cnt (conflict_cnt),
`endif
        .alu_o      (alu_o)
    );

    // Reference combinational RV32 ALU; undefined opcodes return 0.
    always_comb begin
        alu_o = 32'd0;
        case (alu_op)
            ADD:  alu_o = alu_i1 + alu_i2;
            SUB:  alu_o = alu_i1 - alu_i2;
            SLL:  alu_o = alu_i1 << alu_i2[4:0];
            SLT:  alu_o = {31'd0, $signed(alu_i1) < $signed(alu_i2)};
            SLTU: alu_o = {31'd0, alu_i1 < alu_i2};
            XOR:  alu_o = alu_i1 ^ alu_i2;
            SRL:  alu_o = alu_i1 >> alu_i2[4:0];
            SRA:  alu_o = $signed(alu_i1) >>> alu_i2[4:0];
            OR:   alu_o = alu_i1 | alu_i2;
            AND:  alu_o = alu_i1 & alu_i2;
            default: alu_o = 32'd0;
        endcase
    end

    task automatic chk1(input string nm, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", nm, obs, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic drive0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag);
        req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
    endtask

    task automatic drive1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag);
        req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single op on port p with response ready; result checked in its one valid cycle.
    task automatic do_op(input bit p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] exp, input string nm);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        if (p) drive1(op, a, b, tag);
        else   drive0(op, a, b, tag);
        #1;
        chk1({nm, "_ready"}, p ? req1_ready : req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        chk1 ({nm, "_valid"}, p ? rsp1_valid : rsp0_valid, 1'b1);
        chk32({nm, "_data"},  p ? rsp1_data  : rsp0_data, exp);
        chk32({nm, "_tag"},   32'(p ? rsp1_tag : rsp0_tag), 32'(tag));
        chk1 ({nm, "_other"}, p ? rsp0_valid : rsp1_valid, 1'b0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd1; req0_b = 32'd1; req0_tag = 4'd0;
        req1_valid = 1'b0; req1_op = ADD; req1_a = 32'd0; req1_b = 32'd0; req1_tag = 4'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1 ("rst_req0_ready", req0_ready, 1'b0);
        chk1 ("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk1 ("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk32("rst_alu_i1", alu_i1, 32'd0);
        chk32("rst_rsp0_data", rsp0_data, 32'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Single ADD with the result held under backpressure
        drive0(ADD, 32'd5, 32'd7, 4'd3);
        #1;
        chk1("t1_req0_ready", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        #1;
        chk32("t1_alu_i1", alu_i1, 32'd5);
        chk32("t1_alu_i2", alu_i2, 32'd7);
        chk1 ("t1_rsp0_early", rsp0_valid, 1'b0);
        step();
        chk1 ("t1_rsp0_valid", rsp0_valid, 1'b1);
        chk32("t1_rsp0_data", rsp0_data, 32'd12);
        chk32("t1_rsp0_tag", 32'(rsp0_tag), 32'd3);
        chk1 ("t1_rsp1_valid", rsp1_valid, 1'b0);
        step();
        chk1 ("t1_hold_valid", rsp0_valid, 1'b1);
        chk32("t1_hold_data", rsp0_data, 32'd12);
        chk32("t1_idle_alu_i1", alu_i1, 32'd0);
        rsp0_ready = 1'b1;
        step();
        chk1("t1_popped", rsp0_valid, 1'b0);

        // Contention: both valid for 10 cycles, responses always ready
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive0(SUB, 32'd10, 32'd3, 4'd1);
        drive1(SLL, 32'd1, 32'd4, 4'd2);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk1("cont_ready0", req0_ready, (i % 2) == 0);
            chk1("cont_ready1", req1_ready, (i % 2) == 1);
            if (i >= 2 && (i % 2) == 0) begin
                chk1 ("cont_rsp0_valid", rsp0_valid, 1'b1);
                chk32("cont_rsp0_data", rsp0_data, 32'd7);
            end
            if (i >= 3 && (i % 2) == 1) begin
                chk1 ("cont_rsp1_valid", rsp1_valid, 1'b1);
                chk32("cont_rsp1_data", rsp1_data, 32'd16);
                chk32("cont_rsp1_tag", 32'(rsp1_tag), 32'd2);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`ifdef ALU_ARB_STATS_EN
        chk32("stats_grant0", grant0_cnt, 32'd6);
        chk32("stats_grant1", grant1_cnt, 32'd5);
        chk32("stats_conflict", conflict_cnt, 32'd10);
`endif
        repeat (3) step();
        chk1("drain_rsp0", rsp0_valid, 1'b0);
        chk1("drain_rsp1", rsp1_valid, 1'b0);

        // Backpressure on port 0 while port 1 keeps issuing, then bypass re-accept
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        drive0(ADD, 32'd1, 32'd2, 4'd5);
        #1;
        chk1("bp_acc0", req0_ready, 1'b1);
        step();
        drive0(XOR, 32'h0000_00F0, 32'h0000_00FF, 4'd6);
        #1;
        chk1("bp_blk_outst", req0_ready, 1'b0);
        step();
        drive1(OR, 32'h0000_000F, 32'h0000_00F0, 4'd7);
        #1;
        chk32("bp_rsp0_data", rsp0_data, 32'd3);
        chk1 ("bp_blk_held", req0_ready, 1'b0);
        chk1 ("bp_req1_ready", req1_ready, 1'b1);
        step();
        req1_valid = 1'b0;
        #1;
        chk1 ("bp_hold_valid", rsp0_valid, 1'b1);
        chk32("bp_hold_tag", 32'(rsp0_tag), 32'd5);
        chk1 ("bp_blk_still", req0_ready, 1'b0);
        step();
        chk1 ("bp_rsp1_valid", rsp1_valid, 1'b1);
        chk32("bp_rsp1_data", rsp1_data, 32'h0000_00FF);
        chk32("bp_rsp1_tag", 32'(rsp1_tag), 32'd7);
        chk32("bp_rsp0_stable", rsp0_data, 32'd3);
        rsp0_ready = 1'b1;
        #1;
        chk1("bp_bypass", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        #1;
        chk1("bp_after_pop", rsp0_valid, 1'b0);
        step();
        chk1 ("bp_new_valid", rsp0_valid, 1'b1);
        chk32("bp_new_data", rsp0_data, 32'h0000_000F);
        chk32("bp_new_tag", 32'(rsp0_tag), 32'd6);
        step();
        chk1("bp_new_popped", rsp0_valid, 1'b0);

        // Signed/shift ops and an undefined opcode
        do_op(1'b1, SRA,     32'h8000_0000, 32'd4, 4'd8,  32'hF800_0000, "sra");
        do_op(1'b1, SRL,     32'h8000_0000, 32'd4, 4'd12, 32'h0800_0000, "srl");
        do_op(1'b0, SLT,     32'hFFFF_FFFF, 32'd0, 4'd9,  32'd1,         "slt");
        do_op(1'b0, SLTU,    32'hFFFF_FFFF, 32'd0, 4'd10, 32'd0,         "sltu");
        do_op(1'b1, 4'b1111, 32'd5,         32'd5, 4'd11, 32'd0,         "undef");
        do_op(1'b0, AND,     32'hF0F0_1234, 32'h0FF0_FFFF, 4'd15, 32'h00F0_1234, "and");

        // Reset mid-operation discards both the held and the in-flight result
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive1(ADD, 32'd2, 32'd3, 4'd4);
        step();
        req1_valid = 1'b0;
        step();
        chk1("mid_rsp1_held", rsp1_valid, 1'b1);
        drive0(ADD, 32'd1, 32'd1, 4'd1);
        #1;
        chk1("mid_acc0", req0_ready, 1'b1);
        step();
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk1 ("mid_rsp0_valid", rsp0_valid, 1'b0);
        chk1 ("mid_rsp1_valid", rsp1_valid, 1'b0);
        chk1 ("mid_req0_ready", req0_ready, 1'b0);
        chk1 ("mid_req1_ready", req1_ready, 1'b0);
        chk32("mid_rsp1_data", rsp1_data, 32'd0);
        chk32("mid_alu_i1", alu_i1, 32'd0);
`ifdef ALU_ARB_STATS_EN
        chk32("mid_grant0_cnt", grant0_cnt, 32'd0);
        chk32("mid_conflict_cnt", conflict_cnt, 32'd0);
`endif
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("post_rsp0_valid", rsp0_valid, 1'b0);
            chk1("post_rsp1_valid", rsp1_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
